// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 keyboard controller
package ps2_pkg;

    // Register map
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // Scan-code prefixes
    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // Event layout: {ext, brk, code[7:0]}
    localparam int EVT_W        = 10;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_BRK_BIT  = 8;
    localparam int EVT_EXT_BIT  = 9;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchronizer, falling-edge detect, frame FSM and timeout
// Ports: clk/rst (async active-low), en_i holds the FSM idle when low,
//        ps2k_clk_i/ps2k_data_i raw pins; byte_valid_o/byte_o report an accepted
//        byte, perr_pulse_o/ferr_pulse_o report parity and framing/timeout errors.
//        All outputs are single-cycle and combinational from the registered state.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       ps2k_clk_i,
    input  logic       ps2k_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       perr_pulse_o,
    output logic       ferr_pulse_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] clk_sync_q, data_sync_q;
    logic       clk_prev_q;
    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fall, din, timeout;

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign din     = data_sync_q[1];
    assign timeout = (state_q != RX_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));
    assign byte_o  = shift_q;

    // Synchronizers reset to the idle-high pin level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2k_clk_i};
            data_sync_q <= {data_sync_q[0], ps2k_data_i};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        byte_valid_o = 1'b0;
        perr_pulse_o = 1'b0;
        ferr_pulse_o = 1'b0;
        tmo_d        = (state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;

        if (!en_i) begin
            state_d = RX_IDLE;
        end else if (timeout) begin
            state_d      = RX_IDLE;
            ferr_pulse_o = 1'b1;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!din) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = din;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d      = RX_IDLE;
                    perr_pulse_o = ~(^{shift_q, par_q});
                    ferr_pulse_o = ~din;
                    byte_valid_o = din & (^{shift_q, par_q});
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard controller top: decoder, event FIFO, registers, interrupt
// Ports: clk/rst (async active-low); ps2k_clk/ps2k_data raw pins;
//        req/we/addr/wdata register request, ack/rdata one-cycle registered response;
//        interrupt is a level output while IRQ_EN is set and events are pending.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2k_clk,
    input  logic        ps2k_data,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        interrupt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic       rx_valid, rx_perr, rx_ferr;
    logic [7:0] rx_byte;

    logic en_q, en_d, irq_en_q, irq_en_d;
    logic ext_q, ext_d, brk_q, brk_d;
    logic ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic ack_q, ack_d, int_q, int_d;
    logic [31:0] rdata_q, rdata_d;
    logic [EVT_W-1:0] mem_q [FIFO_DEPTH];

    logic acc, rd, wr, is_prefix, push, push_ok, pop, full, empty;
    logic [2:0] w1c;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:3];

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_q),
        .ps2k_clk_i   (ps2k_clk),
        .ps2k_data_i  (ps2k_data),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .perr_pulse_o (rx_perr),
        .ferr_pulse_o (rx_ferr)
    );

    always_comb begin
        // A request landing on an ack cycle is dropped.
        acc       = req & ~ack_q;
        rd        = acc & ~we;
        wr        = acc & we;
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        is_prefix = (rx_byte == PFX_EXT) || (rx_byte == PFX_BRK);
        push      = rx_valid & ~is_prefix;
        pop       = rd & (addr == ADDR_DATA) & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok   = push & (~full | pop);
        w1c       = (wr && addr == ADDR_STATUS) ? wdata[2:0] : 3'b000;

        ext_d = ext_q;
        brk_d = brk_q;
        if (!en_q || rx_perr || rx_ferr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PFX_EXT)      ext_d = 1'b1;
            else if (rx_byte == PFX_BRK) brk_d = 1'b1;
            else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        wptr_d = wptr_q + PW'(push_ok);
        rptr_d = rptr_q + PW'(pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Hardware set has priority over software clear.
        perr_d = (perr_q & ~w1c[0]) | rx_perr;
        ferr_d = (ferr_q & ~w1c[1]) | rx_ferr;
        ovf_d  = (ovf_q  & ~w1c[2]) | (push & full & ~pop);

        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (wr && addr == ADDR_CTRL) begin
            en_d     = wdata[0];
            irq_en_d = wdata[1];
        end

        rdata_d = '0;
        if (rd) begin
            case (addr)
                ADDR_DATA:   if (!empty) rdata_d = {1'b1, 21'b0, mem_q[rptr_q]};
                ADDR_STATUS: rdata_d = {9'b0, 7'(count_q), 13'b0, ovf_q, ferr_q, perr_q};
                ADDR_CTRL:   rdata_d = {30'b0, irq_en_q, en_q};
                default:     rdata_d = '0;
            endcase
        end

        ack_d = acc;
        int_d = irq_en_q & ~empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            int_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            int_q    <= int_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= {ext_q, brk_q, rx_byte};
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign interrupt = int_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - scoreboard bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2k_clk = 1'b1;
    logic        ps2k_data = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic [31:0] rdata;
    logic        interrupt;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    ps2_kbd_ctrl #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2k_clk  (ps2k_clk),
        .ps2k_data (ps2k_data),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    // Monitor: every ack consumes one expected response.
    always @(negedge clk) begin
        if (rst && ack) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_ack rdata=%h expected no response", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata === e) n_pass++;
                else $display("FAIL reg_rdata got=%h expected=%h", rdata, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_op(input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        exp_q.push_back(exp);
        req = 1'b1; we = w; addr = a; wdata = d;
        wait_cyc(1);
        req = 1'b0; we = 1'b0;
        wait_cyc(1);
    endtask

    // nbits < 8 abandons the frame after that many data bits.
    // pop_exp >= 0 issues a DATA read on the cycle the stop bit's push lands.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits,
                              input longint pop_exp);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (nbits < 8 && i == nbits + 1) begin
                ps2k_data = 1'b1;
                return;
            end
            ps2k_data = fr[i];
            wait_cyc(10);
            ps2k_clk = 1'b0;
            if (i == 10 && pop_exp >= 0) begin
                wait_cyc(2);
                exp_q.push_back(pop_exp[31:0]);
                req = 1'b1; we = 1'b0; addr = 2'd0;
                wait_cyc(1);
                req = 1'b0;
                wait_cyc(17);
            end else begin
                wait_cyc(20);
            end
            ps2k_clk = 1'b1;
            wait_cyc(10);
        end
        ps2k_data = 1'b1;
    endtask

    task automatic good(input logic [7:0] d);
        send_frame(d, 1'b0, 8, -1);
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_ack", {31'b0, ack}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_int", {31'b0, interrupt}, 32'd0);
        rst = 1'b1;
        wait_cyc(2);
        reg_op(1'b0, 2'd1, 0, 32'h0000_0000);
        reg_op(1'b0, 2'd2, 0, 32'h0000_0000);

        // Make code
        reg_op(1'b1, 2'd2, 32'h3, 32'h0);
        reg_op(1'b0, 2'd2, 0, 32'h0000_0003);
        good(8'h1C);
        chk("make_int", {31'b0, interrupt}, 32'd1);
        reg_op(1'b0, 2'd1, 0, 32'h0001_0000);
        reg_op(1'b0, 2'd0, 0, 32'h8000_001C);
        chk("make_int_clear", {31'b0, interrupt}, 32'd0);
        reg_op(1'b0, 2'd0, 0, 32'h0000_0000);
        reg_op(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0);
        reg_op(1'b0, 2'd3, 0, 32'h0000_0000);

        // Extended break and other prefix combos
        good(8'hE0); good(8'hF0); good(8'h6B);
        reg_op(1'b0, 2'd1, 0, 32'h0001_0000);
        reg_op(1'b0, 2'd0, 0, 32'h8000_036B);
        good(8'hF0); good(8'h1C);
        good(8'hE0); good(8'h75);
        reg_op(1'b0, 2'd0, 0, 32'h8000_011C);
        reg_op(1'b0, 2'd0, 0, 32'h8000_0275);

        // Bad parity
        send_frame(8'h1C, 1'b1, 8, -1);
        reg_op(1'b0, 2'd1, 0, 32'h0000_0001);
        reg_op(1'b1, 2'd1, 32'h1, 32'h0);
        reg_op(1'b0, 2'd1, 0, 32'h0000_0000);

        // Timeout
        send_frame(8'h55, 1'b0, 4, -1);
        wait_cyc(TMO + 100);
        reg_op(1'b0, 2'd1, 0, 32'h0000_0002);
        reg_op(1'b1, 2'd1, 32'h7, 32'h0);
        good(8'h29);
        reg_op(1'b0, 2'd1, 0, 32'h0001_0000);
        reg_op(1'b0, 2'd0, 0, 32'h8000_0029);

        // Overflow
        for (int i = 0; i < 17; i++) good(8'h10 + 8'(i));
        chk("full_int", {31'b0, interrupt}, 32'd1);
        reg_op(1'b0, 2'd1, 0, 32'h0010_0004);
        for (int i = 0; i < 16; i++) reg_op(1'b0, 2'd0, 0, 32'h8000_0010 + 32'(i));
        reg_op(1'b0, 2'd0, 0, 32'h0000_0000);
        reg_op(1'b1, 2'd1, 32'h4, 32'h0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) good(8'h30 + 8'(i));
        send_frame(8'h40, 1'b0, 8, 64'h8000_0030);
        reg_op(1'b0, 2'd1, 0, 32'h0010_0000);
        for (int i = 1; i < 17; i++) reg_op(1'b0, 2'd0, 0, 32'h8000_0030 + 32'(i));
        reg_op(1'b0, 2'd1, 0, 32'h0000_0000);

        // Reset mid-frame
        good(8'h1C);
        send_frame(8'hA5, 1'b0, 4, -1);
        rst = 1'b0;
        wait_cyc(3);
        chk("midrst_ack", {31'b0, ack}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_int", {31'b0, interrupt}, 32'd0);
        rst = 1'b1;
        wait_cyc(2);
        reg_op(1'b0, 2'd1, 0, 32'h0000_0000);
        reg_op(1'b0, 2'd2, 0, 32'h0000_0000);
        reg_op(1'b1, 2'd2, 32'h3, 32'h0);
        good(8'h5A);
        reg_op(1'b0, 2'd0, 0, 32'h8000_005A);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_cyc(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
